// File: rtl/keypad_pkg.sv
// Shared keypad definitions: event field widths, width helpers for codes and
// counters, and the strobe/return polarity helper also used by the 7-segment
// display multiplexer.
package keypad_pkg;

  // An event is {key code, release flag}; the release flag is one bit.
  localparam int unsigned EVT_REL_W = 1;

  // Bits needed to index n distinct values, never less than 1.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Key code width for a rows x cols matrix.
  function automatic int unsigned code_width(input int unsigned rows, input int unsigned cols);
    return width_of(rows * cols);
  endfunction

  // Full event width as stored in the event queue.
  function automatic int unsigned event_width(input int unsigned rows, input int unsigned cols);
    return code_width(rows, cols) + EVT_REL_W;
  endfunction

  // Width of a counter that must be able to hold the value limit.
  function automatic int unsigned count_width(input int unsigned limit);
    return width_of(limit + 1);
  endfunction

  // Electrical level for a logical "active" state under the chosen polarity.
  function automatic logic drive_level(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous first-word fall-through FIFO for keypad events.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push/wdata write request; ignored when full unless a pop happens in the same cycle
//   pop        removes the head; ignored when empty
//   rdata      head word; holds the last popped word while empty (0 after reset)
//   empty/full occupancy flags
module key_event_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] last;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? last : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        last   <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scan_queue.sv
// Matrix keypad scanner with per-key debounce and a press/release event queue.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   row_in       raw row returns (asynchronous)
//   col_out      column strobes, one active at a time
//   key_valid    event queue head valid
//   key_code     head key index = row*COLS+col
//   key_release  head event type (0 press, 1 release)
//   key_ready    consumer accepts head when key_valid && key_ready
//   any_pressed  OR of all debounced key states
//   overflow     sticky: an event was dropped on a full queue
//   ovf_clr      one-cycle clear for overflow (set wins)
module keypad_scan_queue
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ROWS-1:0]                    row_in,
  output logic [COLS-1:0]                    col_out,
  output logic                               key_valid,
  output logic [code_width(ROWS, COLS)-1:0]  key_code,
  output logic                               key_release,
  input  logic                               key_ready,
  output logic                               any_pressed,
  output logic                               overflow,
  input  logic                               ovf_clr
);

  localparam int unsigned NK  = ROWS * COLS;
  localparam int unsigned KW  = code_width(ROWS, COLS);
  localparam int unsigned EW  = event_width(ROWS, COLS);
  localparam int unsigned DW  = width_of(SCAN_DIV);
  localparam int unsigned CLW = width_of(COLS);
  localparam int unsigned CW  = count_width(DEBOUNCE);

  logic [ROWS-1:0] sync1;
  logic [ROWS-1:0] sync2;
  logic [ROWS-1:0] row_cap;   // logical "pressed" per row for the active column
  logic [DW-1:0]   dwell;
  logic [CLW-1:0]  col;
  logic [NK-1:0]   deb;
  logic [CW-1:0]   cnt [NK];

  logic            walk;
  logic            sample;
  logic [KW-1:0]   cur_code;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            drop;
  logic [EW-1:0]   evt_in;
  logic [EW-1:0]   evt_out;

  // Dwell cycles 3..ROWS+2 each visit one row of the captured column.
  always_comb begin
    walk     = 1'b0;
    sample   = 1'b0;
    cur_code = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (32'(dwell) == r + 3) begin
        walk     = 1'b1;
        sample   = row_cap[r];
        cur_code = KW'(r * COLS + 32'(col));
      end
    end
  end

  // A push fires on the sample that would bring the counter to DEBOUNCE.
  assign push   = walk && (sample != deb[cur_code]) && (cnt[cur_code] == CW'(DEBOUNCE - 1));
  assign evt_in = {cur_code, deb[cur_code]};
  assign pop    = key_valid && key_ready;
  assign drop   = push && full && !pop;

  always_comb begin
    col_out = '0;
    for (int unsigned c = 0; c < COLS; c++) col_out[c] = drive_level(CLW'(c) == col, ACTIVE_LOW);
  end

  assign any_pressed = |deb;
  assign key_valid   = !empty;
  assign key_code    = evt_out[EW-1:1];
  assign key_release = evt_out[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= {ROWS{ACTIVE_LOW}};
      sync2    <= {ROWS{ACTIVE_LOW}};
      row_cap  <= '0;
      dwell    <= '0;
      col      <= '0;
      deb      <= '0;
      overflow <= 1'b0;
      for (int unsigned k = 0; k < NK; k++) cnt[k] <= '0;
    end else begin
      sync1 <= row_in;
      sync2 <= sync1;

      if (dwell == DW'(SCAN_DIV - 1)) begin
        dwell <= '0;
        col   <= (col == CLW'(COLS - 1)) ? '0 : col + CLW'(1);
      end else begin
        dwell <= dwell + DW'(1);
      end

      if (dwell == DW'(2)) row_cap <= sync2 ^ {ROWS{ACTIVE_LOW}};

      // The debounced bit flips even if the queue drops the event.
      if (walk) begin
        if (sample == deb[cur_code]) begin
          cnt[cur_code] <= '0;
        end else if (push) begin
          deb[cur_code] <= ~deb[cur_code];
          cnt[cur_code] <= '0;
        end else begin
          cnt[cur_code] <= cnt[cur_code] + CW'(1);
        end
      end

      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  key_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (evt_in),
    .pop   (pop),
    .rdata (evt_out),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_keypad_scan_queue.sv
// Self-checking bench for keypad_scan_queue (4x4, SCAN_DIV=8, DEBOUNCE=2, FIFO_DEPTH=2).
module tb_keypad_scan_queue;

  localparam int R     = 4;
  localparam int C     = 4;
  localparam int NK    = R * C;
  localparam int FRAME = 32;
  localparam int DEB   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_release;
  logic        key_ready = 1'b1;
  logic        any_pressed;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  logic [NK-1:0] mat = '0;   // physical key state, index row*C+col

  int checks = 0;
  int errors = 0;

  typedef struct { int key; bit rel; } ev_t;
  ev_t got_q[$];
  ev_t exp_q[$];
  bit  any_seen = 1'b0;

  // model state for the random phase
  bit [NK-1:0] mdeb;
  int          mrun [NK];

  keypad_scan_queue #(
    .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(2), .FIFO_DEPTH(2), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_valid(key_valid), .key_code(key_code), .key_release(key_release),
    .key_ready(key_ready), .any_pressed(any_pressed), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row is pulled low while a pressed key sits on the driven column.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (mat[r*C+c] && (col_out[c] === 1'b0)) row_in[r] = 1'b0;
  end

  // Log every pop; sampled after the input changes made at the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (!rst && key_valid && key_ready) got_q.push_back('{int'(key_code), key_release});
    if (any_pressed) any_seen = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ev(input string name, input int idx, input int code, input bit rel);
    checks++;
    if (idx >= got_q.size()) begin
      errors++;
      $display("FAIL %s: event %0d missing (have %0d), expected code %0d release %0d",
               name, idx, got_q.size(), code, rel);
    end else if (got_q[idx].key != code || got_q[idx].rel != rel) begin
      errors++;
      $display("FAIL %s: event %0d got code %0d release %0d expected code %0d release %0d",
               name, idx, got_q[idx].key, got_q[idx].rel, code, rel);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the falling edge just after the column index wraps to 0.
  task automatic wait_frame();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = col_out;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col_out == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = col_out;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL frame_start: no wrap to column 0 within 40 clocks, col_out=%b", col_out);
    end
  endtask

  task automatic frames(input int n);
    repeat (n) wait_frame();
  endtask

  // Frame-level reference: every key sees one sample per frame, in column-then-row order.
  task automatic model_frame(input logic [NK-1:0] m);
    for (int c = 0; c < C; c++)
      for (int r = 0; r < R; r++) begin
        int k;
        k = r*C + c;
        if (m[k] == mdeb[k]) mrun[k] = 0;
        else begin
          mrun[k]++;
          if (mrun[k] == DEB) begin
            mdeb[k] = m[k];
            mrun[k] = 0;
            exp_q.push_back('{k, !m[k]});
          end
        end
      end
  endtask

  typedef struct { int at; logic [3:0] col; logic valid; logic ovf; logic any; } col_vec_t;
  typedef struct { int r; int c; int code; int hold; } key_vec_t;

  col_vec_t cv[7];
  key_vec_t kv[5];

  initial begin
    int elapsed;

    cv[0] = '{0,  4'b1110, 1'b0, 1'b0, 1'b0};
    cv[1] = '{7,  4'b1110, 1'b0, 1'b0, 1'b0};
    cv[2] = '{8,  4'b1101, 1'b0, 1'b0, 1'b0};
    cv[3] = '{16, 4'b1011, 1'b0, 1'b0, 1'b0};
    cv[4] = '{24, 4'b0111, 1'b0, 1'b0, 1'b0};
    cv[5] = '{31, 4'b0111, 1'b0, 1'b0, 1'b0};
    cv[6] = '{32, 4'b1110, 1'b0, 1'b0, 1'b0};

    kv[0] = '{2, 1, 9,  6};
    kv[1] = '{0, 0, 0,  3};
    kv[2] = '{3, 3, 15, 3};
    kv[3] = '{1, 2, 6,  4};
    kv[4] = '{3, 0, 12, 3};

    // reset and column timing
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_key_code", key_code, 0);
    check("rst_key_release", key_release, 0);
    elapsed = 0;
    for (int i = 0; i < 7; i++) begin
      while (elapsed < cv[i].at) begin
        @(negedge clk);
        elapsed++;
      end
      check($sformatf("col_out@%0d", cv[i].at), col_out, cv[i].col);
      check($sformatf("key_valid@%0d", cv[i].at), key_valid, cv[i].valid);
      check($sformatf("overflow@%0d", cv[i].at), overflow, cv[i].ovf);
      check($sformatf("any_pressed@%0d", cv[i].at), any_pressed, cv[i].any);
    end

    // single keys: press then release
    for (int i = 0; i < 5; i++) begin
      got_q.delete();
      wait_frame();
      mat[kv[i].r*C + kv[i].c] = 1'b1;
      frames(3);
      check($sformatf("press_count_k%0d", kv[i].code), got_q.size(), 1);
      check_ev($sformatf("press_k%0d", kv[i].code), 0, kv[i].code, 1'b0);
      check($sformatf("any_pressed_k%0d", kv[i].code), any_pressed, 1);
      frames(kv[i].hold - 3);
      mat = '0;
      frames(3);
      check_ev($sformatf("release_k%0d", kv[i].code), 1, kv[i].code, 1'b1);
      frames(3);
      check($sformatf("total_events_k%0d", kv[i].code), got_q.size(), 2);
    end

    // one-frame glitches never reach DEBOUNCE
    got_q.delete();
    any_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_frame();
      mat[0] = (i % 2 == 0);
    end
    mat = '0;
    frames(2);
    check("glitch_events", got_q.size(), 0);
    check("glitch_any_pressed", any_seen, 0);

    // overflow: three presses with the consumer stalled
    got_q.delete();
    key_ready = 1'b0;
    wait_frame();
    mat[0] = 1'b1; mat[5] = 1'b1; mat[10] = 1'b1;
    frames(3);
    check("ovf_valid", key_valid, 1);
    check("ovf_head_code", key_code, 0);
    check("ovf_head_rel", key_release, 0);
    check("ovf_set", overflow, 1);
    tick(5);
    check("ovf_head_stable", key_code, 0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    key_ready = 1'b1;
    tick(4);
    check("ovf_drain_count", got_q.size(), 2);
    check_ev("ovf_drain0", 0, 0, 1'b0);
    check_ev("ovf_drain1", 1, 5, 1'b0);
    check("ovf_empty_valid", key_valid, 0);
    check("ovf_empty_hold_code", key_code, 5);
    mat = '0;
    frames(3);

    // scan order: column first, then row
    got_q.delete();
    wait_frame();
    mat[1] = 1'b1; mat[4] = 1'b1;
    frames(3);
    check("order_count", got_q.size(), 2);
    check_ev("order0", 0, 4, 1'b0);
    check_ev("order1", 1, 1, 1'b0);
    mat = '0;
    frames(3);

    // reset while a key is held
    got_q.delete();
    wait_frame();
    mat[15] = 1'b1;
    frames(3);
    check_ev("held_press", 0, 15, 1'b0);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    got_q.delete();
    check("midrst_valid", key_valid, 0);
    check("midrst_any", any_pressed, 0);
    check("midrst_col", col_out, 4'b1110);
    tick(FRAME);
    check("midrst_no_early", got_q.size(), 0);
    tick(FRAME * 3);
    check("midrst_count", got_q.size(), 1);
    check_ev("midrst_repress", 0, 15, 1'b0);
    mat = '0;
    frames(3);

    // randomized frames against the frame-level model
    rst = 1'b1;
    tick(2);
    got_q.delete();
    exp_q.delete();
    mdeb = '0;
    for (int k = 0; k < NK; k++) mrun[k] = 0;
    mat = NK'($urandom);
    model_frame(mat);
    rst = 1'b0;
    for (int f = 0; f < 40; f++) begin
      wait_frame();
      check($sformatf("rand_any_f%0d", f), any_pressed, |mdeb);
      for (int k = 0; k < NK; k++)
        if ($urandom_range(3) == 0) mat[k] = ~mat[k];
      model_frame(mat);
    end
    wait_frame();
    tick(4);
    check("rand_event_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_ev($sformatf("rand_ev%0d", i), i, exp_q[i].key, exp_q[i].rel);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
